// File: rtl/core_avl_arbiter_2m1s.sv
// Two-master / one-slave Avalon arbiter with write-burst locking and an in-order read tag FIFO.
// Define CORE_AVL_ARB_FIXED_PRIO_EN to make m0 win every tie instead of round robin.
module core_avl_arbiter_2m1s #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BURST_W     = 4,
  parameter int unsigned OUTST_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rest,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W/8-1:0]   m0_byte_en,
  input  logic [DATA_W-1:0]     m0_write_data,
  input  logic                  m0_begin_burst_transfer,
  input  logic [BURST_W-1:0]    m0_burst_count,
  output logic                  m0_request_ready,
  output logic [DATA_W-1:0]     m0_read_data,
  output logic                  m0_read_data_valid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W/8-1:0]   m1_byte_en,
  input  logic [DATA_W-1:0]     m1_write_data,
  input  logic                  m1_begin_burst_transfer,
  input  logic [BURST_W-1:0]    m1_burst_count,
  output logic                  m1_request_ready,
  output logic [DATA_W-1:0]     m1_read_data,
  output logic                  m1_read_data_valid,
  output logic [ADDR_W-1:0]     s_address,
  output logic                  s_read,
  output logic                  s_write,
  output logic [DATA_W/8-1:0]   s_byte_en,
  output logic [DATA_W-1:0]     s_write_data,
  output logic                  s_begin_burst_transfer,
  output logic [BURST_W-1:0]    s_burst_count,
  input  logic                  s_request_ready,
  input  logic [DATA_W-1:0]     s_read_data,
  input  logic                  s_read_data_valid,
  output logic                  err_unexp_rdata
);

  localparam int unsigned PtrW = $clog2(OUTST_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {ArbIdle, ArbWburst} state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic [BURST_W-1:0] wcnt_q, wcnt_d;

  logic               fifo_owner_q [OUTST_DEPTH];
  logic [BURST_W-1:0] fifo_beats_q [OUTST_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q;
  logic [BURST_W-1:0] rbeat_q;

  logic fifo_not_full, fifo_empty;
  logic elig0, elig1, win, tie_win, grant_valid;
  logic sel_read, sel_write;
  logic [BURST_W-1:0] sel_burst, push_beats, head_beats;
  logic accept, push, pop, hit, head_owner;

  assign fifo_not_full = (count_q != CntW'(OUTST_DEPTH));
  assign fifo_empty    = (count_q == '0);
  assign elig0 = (m0_read & fifo_not_full) | m0_write;
  assign elig1 = (m1_read & fifo_not_full) | m1_write;

`ifdef CORE_AVL_ARB_FIXED_PRIO_EN
  assign tie_win = 1'b0;
`else
  logic last_grant_q;
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      last_grant_q <= 1'b1;
    end else if (accept && state_q == ArbIdle) begin
      last_grant_q <= win;
    end
  end
  assign tie_win = ~last_grant_q;
`endif

  // Arbitration: the burst owner is locked in; otherwise tie goes to tie_win.
  always_comb begin
    win         = 1'b0;
    grant_valid = 1'b0;
    if (state_q == ArbWburst) begin
      win         = owner_q;
      grant_valid = 1'b1;
    end else begin
      grant_valid = elig0 | elig1;
      win         = (elig0 & elig1) ? tie_win : elig1;
    end
  end

  assign sel_read  = win ? m1_read        : m0_read;
  assign sel_write = win ? m1_write       : m0_write;
  assign sel_burst = win ? m1_burst_count : m0_burst_count;

  // Output process: slave command mux and master handshakes.
  always_comb begin
    s_address              = win ? m1_address    : m0_address;
    s_byte_en              = win ? m1_byte_en    : m0_byte_en;
    s_write_data           = win ? m1_write_data : m0_write_data;
    s_burst_count          = sel_burst;
    s_begin_burst_transfer = ~rest & grant_valid &
                             (win ? m1_begin_burst_transfer : m0_begin_burst_transfer);
    s_read           = ~rest & grant_valid & (state_q == ArbIdle) & sel_read & fifo_not_full;
    s_write          = ~rest & grant_valid & sel_write;
    m0_request_ready = ~rest & grant_valid & ~win & s_request_ready;
    m1_request_ready = ~rest & grant_valid & win & s_request_ready;
  end

  assign accept     = (s_read | s_write) & s_request_ready;
  assign push       = s_read & s_request_ready;
  assign push_beats = (sel_burst == '0) ? BURST_W'(1) : sel_burst;

  assign head_owner = fifo_owner_q[rd_ptr_q];
  assign head_beats = fifo_beats_q[rd_ptr_q];
  assign hit        = ~rest & s_read_data_valid & ~fifo_empty;
  assign pop        = hit & (rbeat_q == head_beats - BURST_W'(1));

  assign m0_read_data       = s_read_data;
  assign m1_read_data       = s_read_data;
  assign m0_read_data_valid = hit & ~head_owner;
  assign m1_read_data_valid = hit & head_owner;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      ArbIdle: begin
        if (s_write && s_request_ready && sel_burst > BURST_W'(1)) begin
          state_d = ArbWburst;
          owner_d = win;
          wcnt_d  = sel_burst - BURST_W'(1);
        end
      end
      ArbWburst: begin
        if (s_write && s_request_ready) begin
          wcnt_d = wcnt_q - BURST_W'(1);
          if (wcnt_q == BURST_W'(1)) state_d = ArbIdle;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state_q <= ArbIdle;
      owner_q <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      rbeat_q         <= '0;
      err_unexp_rdata <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        rbeat_q  <= '0;
      end else if (hit) begin
        rbeat_q <= rbeat_q + BURST_W'(1);
      end
      if (push && !pop) count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
      if (s_read_data_valid && fifo_empty) err_unexp_rdata <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_owner_q[wr_ptr_q] <= win;
      fifo_beats_q[wr_ptr_q] <= push_beats;
    end
  end

endmodule

// File: tb/tb_core_avl_arbiter_2m1s.sv
// Self-checking bench for core_avl_arbiter_2m1s: directed scenarios plus random traffic
// compared against a queue-based transaction model.
module tb_core_avl_arbiter_2m1s;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rest = 1'b1;
  always #5 clk = ~clk;

  logic        rd [2];
  logic        wr [2];
  logic [31:0] addr [2];
  logic [3:0]  be [2];
  logic [31:0] wd [2];
  logic        bb [2];
  logic [3:0]  bc [2];

  logic        rr0, rr1, rv0, rv1;
  logic [31:0] rdat0, rdat1;
  logic [31:0] s_address, s_write_data, s_rdata;
  logic        s_read, s_write, s_bb, s_rr, s_rvalid, err;
  logic [3:0]  s_byte_en, s_bc;

  core_avl_arbiter_2m1s dut (
    .clk                     (clk),
    .rest                    (rest),
    .m0_address              (addr[0]),
    .m0_read                 (rd[0]),
    .m0_write                (wr[0]),
    .m0_byte_en              (be[0]),
    .m0_write_data           (wd[0]),
    .m0_begin_burst_transfer (bb[0]),
    .m0_burst_count          (bc[0]),
    .m0_request_ready        (rr0),
    .m0_read_data            (rdat0),
    .m0_read_data_valid      (rv0),
    .m1_address              (addr[1]),
    .m1_read                 (rd[1]),
    .m1_write                (wr[1]),
    .m1_byte_en              (be[1]),
    .m1_write_data           (wd[1]),
    .m1_begin_burst_transfer (bb[1]),
    .m1_burst_count          (bc[1]),
    .m1_request_ready        (rr1),
    .m1_read_data            (rdat1),
    .m1_read_data_valid      (rv1),
    .s_address               (s_address),
    .s_read                  (s_read),
    .s_write                 (s_write),
    .s_byte_en               (s_byte_en),
    .s_write_data            (s_write_data),
    .s_begin_burst_transfer  (s_bb),
    .s_burst_count           (s_bc),
    .s_request_ready         (s_rr),
    .s_read_data             (s_rdata),
    .s_read_data_valid       (s_rvalid),
    .err_unexp_rdata         (err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Transaction-level model: outstanding reads as (owner, beats left), burst lock, last grant.
  int q_own [$];
  int q_beats [$];
  bit lg;
  bit lock;
  bit lock_own;
  int lock_rem;
  bit m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'(i) << 12; be[i] = 4'hf;
      wd[i] = 32'hd000 + 32'(i); bb[i] = 1'b0; bc[i] = 4'd1;
    end
    s_rr = 1'b0; s_rvalid = 1'b0; s_rdata = 32'h0;
  endtask

  task automatic do_reset();
    rest = 1'b1; rd[0] = 1'b1; wr[1] = 1'b1; bc[1] = 4'd4; s_rr = 1'b1; s_rvalid = 1'b1;
    #2;
    chk("rst_s_read", s_read, 0);
    chk("rst_s_write", s_write, 0);
    chk("rst_m0_ready", rr0, 0);
    chk("rst_m1_ready", rr1, 0);
    chk("rst_m0_rvalid", rv0, 0);
    chk("rst_m1_rvalid", rv1, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;
    rest = 1'b0;
    clear_inputs();
    q_own.delete(); q_beats.delete();
    lg = 1'b1; lock = 1'b0; lock_own = 1'b0; lock_rem = 0; m_err = 1'b0;
  endtask

  // One clock: predict from the model, compare at negedge, advance the model at posedge.
  task automatic cycle();
    bit full, e0, e1, gv, w, xr, xw, acc, hit;
    int own;
    @(negedge clk);
    full = (q_own.size() == DEPTH);
    e0 = (rd[0] && !full) || wr[0];
    e1 = (rd[1] && !full) || wr[1];
    if (lock) begin
      w = lock_own; gv = 1'b1; xr = 1'b0; xw = wr[w];
    end else begin
      gv = e0 || e1;
`ifdef CORE_AVL_ARB_FIXED_PRIO_EN
      if (e0 && e1) w = 1'b0;
`else
      if (e0 && e1) w = (lg == 1'b1) ? 1'b0 : 1'b1;
`endif
      else w = e1;
      xr = gv && rd[w] && !full;
      xw = gv && wr[w];
    end
    chk("s_read", s_read, xr);
    chk("s_write", s_write, xw);
    chk("m0_ready", rr0, gv && !w && s_rr);
    chk("m1_ready", rr1, gv && w && s_rr);
    if (xr || xw) begin
      chk("s_address", s_address, addr[w]);
      chk("s_burst_count", s_bc, bc[w]);
      if (xw) chk("s_write_data", s_write_data, wd[w]);
    end
    hit = s_rvalid && (q_own.size() > 0);
    own = hit ? q_own[0] : 0;
    chk("m0_rvalid", rv0, hit && own == 0);
    chk("m1_rvalid", rv1, hit && own == 1);
    if (hit) chk("rdata_route", (own == 1) ? rdat1 : rdat0, s_rdata);
    chk("err", err, m_err);
    acc = (xr || xw) && s_rr;
    @(posedge clk);
    if (s_rvalid) begin
      if (q_own.size() == 0) m_err = 1'b1;
      else begin
        q_beats[0] = q_beats[0] - 1;
        if (q_beats[0] == 0) begin
          void'(q_own.pop_front());
          void'(q_beats.pop_front());
        end
      end
    end
    if (acc) begin
      if (xr) begin
        q_own.push_back(int'(w));
        q_beats.push_back((bc[w] == 0) ? 1 : int'(bc[w]));
      end
      if (!lock) lg = w;
      if (xw) begin
        if (lock) begin
          lock_rem--;
          if (lock_rem == 0) lock = 1'b0;
        end else if (bc[w] > 1) begin
          lock = 1'b1; lock_own = w; lock_rem = int'(bc[w]) - 1;
        end
      end
    end
    #1;
  endtask

  initial begin
    clear_inputs();
    do_reset();

    // Both masters single-read; m0 first, each gets its own data.
    rd[0] = 1'b1; rd[1] = 1'b1; s_rr = 1'b1; addr[0] = 32'h100; addr[1] = 32'h200;
    #1 chk("t1_m0_first", rr0, 1);
    cycle();
    rd[0] = 1'b0;
    #1 chk("t1_m1_next", rr1, 1);
    cycle();
    rd[1] = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h11111111;
    #1 chk("t1_d0_m0", rdat0, 32'h11111111);
    chk("t1_d0_not_m1", rv1, 0);
    cycle();
    s_rdata = 32'h22222222;
    #1 chk("t1_d1_m1", rv1, 1);
    cycle();
    s_rvalid = 1'b0;

    // m1 write burst of 4 locks out an m0 read, including through a stall.
    wr[1] = 1'b1; bb[1] = 1'b1; bc[1] = 4'd4; wd[1] = 32'hb0;
    cycle();
    bb[1] = 1'b0; wd[1] = 32'hb1; rd[0] = 1'b1; bc[0] = 4'd1;
    #1 chk("t2_m0_locked", rr0, 0);
    cycle();
    wr[1] = 1'b0;
    #1 chk("t2_stall_locked", rr0, 0);
    cycle();
    wr[1] = 1'b1; wd[1] = 32'hb2;
    cycle();
    wd[1] = 32'hb3;
    #1 chk("t2_last_beat_locked", rr0, 0);
    cycle();
    wr[1] = 1'b0;
    #1 chk("t2_m0_granted", rr0, 1);
    cycle();
    rd[0] = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h33;
    cycle();
    s_rvalid = 1'b0;

    // Four outstanding reads fill the FIFO; a fifth waits, writes still flow.
    rd[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin addr[0] = 32'h400 + 32'(i); cycle(); end
    wr[1] = 1'b1; bc[1] = 4'd1;
    #1 chk("t3_full_blocks_read", rr0, 0);
    chk("t3_write_passes", rr1, 1);
    cycle();
    wr[1] = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h44;
    #1 chk("t3_no_bypass", rr0, 0);
    cycle();
    s_rvalid = 1'b0;
    #1 chk("t3_fifth_accepted", rr0, 1);
    cycle();
    rd[0] = 1'b0; s_rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin s_rdata = 32'h50 + 32'(i); cycle(); end
    s_rvalid = 1'b0;

    // m0 burst read of 3, then m1 single read.
    rd[0] = 1'b1; bc[0] = 4'd3;
    cycle();
    rd[0] = 1'b0; rd[1] = 1'b1; bc[1] = 4'd1;
    cycle();
    rd[1] = 1'b0; s_rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_rdata = 32'h60 + 32'(i);
      #1 chk("t4_route", {30'd0, rv1, rv0}, (i < 3) ? 32'd1 : 32'd2);
      cycle();
    end

    // Unexpected beat with the FIFO drained: dropped and sticky error.
    #1 chk("t5_drop", {30'd0, rv1, rv0}, 0);
    cycle();
    s_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("t5_err_sticky", err, 1);
    do_reset();

    // Continuous single writes from both: grant pattern.
    wr[0] = 1'b1; wr[1] = 1'b1; s_rr = 1'b1;
    for (int i = 0; i < 6; i++) begin
`ifdef CORE_AVL_ARB_FIXED_PRIO_EN
      #1 chk("t6_grant_m1", rr1, 0);
`else
      #1 chk("t6_grant_m1", rr1, 32'(i % 2));
`endif
      cycle();
    end
    clear_inputs();

    // Reset abandons an outstanding read; its late data flags an error.
    rd[0] = 1'b1; s_rr = 1'b1;
    cycle();
    do_reset();
    s_rvalid = 1'b1; s_rdata = 32'h77;
    cycle();
    s_rvalid = 1'b0;
    cycle();
    chk("t7_late_err", err, 1);
    do_reset();

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        int op;
        op = int'($urandom_range(0, 2));
        rd[i] = (op == 1); wr[i] = (op == 2);
        addr[i] = $urandom; wd[i] = $urandom; be[i] = 4'($urandom);
        bb[i] = 1'($urandom); bc[i] = 4'($urandom_range(0, 3));
      end
      s_rr = ($urandom_range(0, 3) != 0);
      s_rvalid = (q_own.size() > 0) && ($urandom_range(0, 1) == 1);
      s_rdata = $urandom;
      cycle();
    end
    chk("rand_final_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
